// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_system request arbiter: state encodings,
// the owner enum used by the arbitration decision, and counter widths.
package mem_arb_pkg;

    // Encodings are fixed so external debug taps can decode the state.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GNT_I = 2'b01;
    localparam logic [1:0] ST_GNT_D = 2'b10;
    localparam logic [1:0] ST_ERR   = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    // Port index used by the per-port response generate loop.
    localparam int N_PORTS  = 2;
    localparam int PORT_I   = 0;
    localparam int PORT_D   = 1;

    // Starve counter covers STARVE_MAX up to 15.
    localparam int STARVE_W = 4;
    // Watchdog counter width; comfortably above any sensible timeout.
    localparam int WDOG_W   = 16;

endpackage

// File: rtl/mem_arb_wdog.sv
// Grant watchdog: counts cycles while enabled, restarts on clear, and flags
// expiry in the LIMIT-th enabled cycle. Only built with MEM_ARB_WDOG_EN.
module mem_arb_wdog #(
    parameter int LIMIT = 64,
    parameter int W     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [W-1:0] cnt_reg;

    assign expire = enable && !clear && (cnt_reg == W'(LIMIT - 1));

    // Cycle counter: cleared on a new grant, advances while the grant waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable && !expire) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the single mem_system between the instruction-fetch port (read
// only) and the data port (read/write). One request is granted at a time; the
// request to mem_system is registered at the grant edge and held until
// ms_done, with at least one idle cycle between grants. D normally wins, but
// after STARVE_MAX consecutive D grants with I waiting, I is forced through.
// Optional grant watchdog: define MEM_ARB_WDOG_EN.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction-fetch port
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data_out,
    output logic              i_done,
    output logic              i_stall,
    output logic              i_hit,
    // data port
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data_in,
    output logic [DATA_W-1:0] d_data_out,
    output logic              d_done,
    output logic              d_stall,
    output logic              d_hit,
    // mem_system request / response
    output logic [ADDR_W-1:0] ms_addr,
    output logic [DATA_W-1:0] ms_data_in,
    output logic              ms_rd,
    output logic              ms_wr,
    input  logic [DATA_W-1:0] ms_data_out,
    input  logic              ms_done,
    input  logic              ms_cachehit,
    input  logic              ms_err,
    // sticky error
    output logic              arb_err
);

    localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

    // Reject configurations the counters cannot represent.
    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("mem_req_arbiter: STARVE_MAX must be 1..15 and TIMEOUT_CYC >= 1");
    end

    logic [1:0]          state_reg,      state_next;
    logic [STARVE_W-1:0] starve_reg,     starve_next;
    logic [ADDR_W-1:0]   ms_addr_reg,    ms_addr_next;
    logic [DATA_W-1:0]   ms_data_in_reg, ms_data_in_next;
    logic                ms_rd_reg,      ms_rd_next;
    logic                ms_wr_reg,      ms_wr_next;
    logic                arb_err_reg,    arb_err_next;

    owner_e              grant_owner;
    logic                in_grant;
    logic                wdog_expire;

    logic [N_PORTS-1:0]  port_req;
    logic [N_PORTS-1:0]  port_done;
    logic [N_PORTS-1:0]  port_hit;
    logic [N_PORTS-1:0]  port_stall;
    logic [DATA_W-1:0]   port_data [N_PORTS];

    assign in_grant = (state_reg == ST_GNT_I) || (state_reg == ST_GNT_D);

    assign port_req[PORT_I] = i_rd;
    assign port_req[PORT_D] = d_rd | d_wr;

    // Per-port response routing: only the current owner sees done/hit/data,
    // and an error completion is never reported as done.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        localparam logic [1:0] OWN_ST = (gi == PORT_I) ? ST_GNT_I : ST_GNT_D;
        assign port_done[gi]  = (state_reg == OWN_ST) && ms_done && !ms_err;
        assign port_hit[gi]   = port_done[gi] && ms_cachehit;
        assign port_data[gi]  = port_done[gi] ? ms_data_out : '0;
        assign port_stall[gi] = port_req[gi] && !port_done[gi];
    end

    assign i_done     = port_done[PORT_I];
    assign i_hit      = port_hit[PORT_I];
    assign i_stall    = port_stall[PORT_I];
    assign i_data_out = port_data[PORT_I];
    assign d_done     = port_done[PORT_D];
    assign d_hit      = port_hit[PORT_D];
    assign d_stall    = port_stall[PORT_D];
    assign d_data_out = port_data[PORT_D];

    assign ms_addr    = ms_addr_reg;
    assign ms_data_in = ms_data_in_reg;
    assign ms_rd      = ms_rd_reg;
    assign ms_wr      = ms_wr_reg;
    assign arb_err    = arb_err_reg;

`ifdef MEM_ARB_WDOG_EN
    mem_arb_wdog #(
        .LIMIT (TIMEOUT_CYC),
        .W     (WDOG_W)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (grant_owner != OWN_NONE),
        .enable (in_grant),
        .expire (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    // Arbitration, grant load/hold and error transitions.
    always_comb begin
        state_next      = state_reg;
        starve_next     = starve_reg;
        ms_addr_next    = ms_addr_reg;
        ms_data_in_next = ms_data_in_reg;
        ms_rd_next      = ms_rd_reg;
        ms_wr_next      = ms_wr_reg;
        arb_err_next    = arb_err_reg;
        grant_owner     = OWN_NONE;

        if (state_reg == ST_IDLE) begin
            if (d_rd && d_wr) begin
                // Simultaneous read and write is not a legal D op.
                state_next   = ST_ERR;
                arb_err_next = 1'b1;
            end else if ((d_rd || d_wr) && !(i_rd && starve_reg == STARVE_MAX_C)) begin
                grant_owner = OWN_D;
            end else if (i_rd) begin
                grant_owner = OWN_I;
            end

            if (grant_owner == OWN_D) begin
                state_next      = ST_GNT_D;
                ms_addr_next    = d_addr;
                ms_data_in_next = d_data_in;
                ms_rd_next      = d_rd;
                ms_wr_next      = d_wr;
                if (!i_rd)
                    starve_next = '0;
                else if (starve_reg != STARVE_MAX_C)
                    starve_next = starve_reg + 1'b1;
            end else if (grant_owner == OWN_I) begin
                state_next      = ST_GNT_I;
                ms_addr_next    = i_addr;
                ms_data_in_next = '0;
                ms_rd_next      = 1'b1;
                ms_wr_next      = 1'b0;
                starve_next     = '0;
            end
        end else if (in_grant) begin
            if (ms_err || wdog_expire) begin
                state_next   = ST_ERR;
                ms_rd_next   = 1'b0;
                ms_wr_next   = 1'b0;
                arb_err_next = 1'b1;
            end else if (ms_done) begin
                // Dropping the op here guarantees the idle cycle mem_system needs.
                state_next = ST_IDLE;
                ms_rd_next = 1'b0;
                ms_wr_next = 1'b0;
            end
        end
        // ST_ERR holds everything until reset.
    end

    // State and registered mem_system request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            starve_reg     <= '0;
            ms_addr_reg    <= '0;
            ms_data_in_reg <= '0;
            ms_rd_reg      <= 1'b0;
            ms_wr_reg      <= 1'b0;
            arb_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_reg     <= starve_next;
            ms_addr_reg    <= ms_addr_next;
            ms_data_in_reg <= ms_data_in_next;
            ms_rd_reg      <= ms_rd_next;
            ms_wr_reg      <= ms_wr_next;
            arb_err_reg    <= arb_err_next;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter; the bench plays mem_system itself.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_rd;
    logic [15:0] i_addr;
    logic [15:0] i_data_out;
    logic        i_done, i_stall, i_hit;
    logic        d_rd, d_wr;
    logic [15:0] d_addr, d_data_in;
    logic [15:0] d_data_out;
    logic        d_done, d_stall, d_hit;
    logic [15:0] ms_addr, ms_data_in;
    logic        ms_rd, ms_wr;
    logic [15:0] ms_data_out;
    logic        ms_done, ms_cachehit, ms_err;
    logic        arb_err;

    int n_cmp = 0;
    int n_err = 0;
    int k;
    logic exp_d;

    mem_req_arbiter #(
        .ADDR_W(16), .DATA_W(16), .STARVE_MAX(4), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_rd(i_rd), .i_addr(i_addr), .i_data_out(i_data_out),
        .i_done(i_done), .i_stall(i_stall), .i_hit(i_hit),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall), .d_hit(d_hit),
        .ms_addr(ms_addr), .ms_data_in(ms_data_in), .ms_rd(ms_rd), .ms_wr(ms_wr),
        .ms_data_out(ms_data_out), .ms_done(ms_done), .ms_cachehit(ms_cachehit),
        .ms_err(ms_err), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; i_rd = 0; i_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_data_in = '0;
        ms_data_out = '0; ms_done = 0; ms_cachehit = 0; ms_err = 0;
        step(); step();
        check("reset ms", {ms_rd, ms_wr, ms_addr, ms_data_in}, 34'h0);
        check("reset err/stall", {arb_err, i_stall, d_stall, i_done, d_done}, 5'b0);
        rst_n = 1'b1;

        // 1: I-only hit round trip
        i_rd = 1; i_addr = 16'h0040; settle();
        check("t1 pre-grant", {i_stall, ms_rd}, 2'b10);
        step();
        check("t1 grant", {ms_rd, ms_wr, ms_addr, ms_data_in}, {2'b10, 16'h0040, 16'h0000});
        ms_done = 1; ms_data_out = 16'hBEEF; ms_cachehit = 1; settle();
        check("t1 done", {i_done, i_hit, i_stall, d_done, d_hit}, 5'b11000);
        check("t1 data", {i_data_out, d_data_out}, {16'hBEEF, 16'h0000});
        $display("txn t1 I read 0040 -> %h", i_data_out);
        step();
        i_rd = 0; ms_done = 0; ms_cachehit = 0; settle();
        check("t1 idle", {ms_rd, i_done}, 2'b00);

        // 2: contention, four D grants then I forced, then D again
        i_addr = 16'h0200; d_addr = 16'h0100; i_rd = 1; d_rd = 1; settle();
        check("t2 both stall", {i_stall, d_stall}, 2'b11);
        for (int g = 0; g < 6; g++) begin
            exp_d = (g != 4);
            step();
            check($sformatf("t2 grant%0d", g), {ms_rd, ms_addr}, {1'b1, exp_d ? 16'h0100 : 16'h0200});
            ms_done = 1; ms_data_out = 16'h1000 + 16'(g); settle();
            check($sformatf("t2 done%0d", g), {i_done, d_done, i_stall, d_stall},
                  exp_d ? 4'b0110 : 4'b1001);
            $display("txn t2 grant %0d -> %s", g, exp_d ? "D" : "I");
            step();
            ms_done = 0; settle();
            check($sformatf("t2 gap%0d", g), {ms_rd, i_done, d_done}, 3'b000);
        end
        i_rd = 0; d_rd = 0;

        // 3: D store miss, done after 10 cycles, request fields held
        d_wr = 1; d_addr = 16'h0808; d_data_in = 16'h1234;
        step();
        for (int c = 0; c < 10; c++) begin
            check($sformatf("t3 hold%0d", c), {ms_addr, ms_data_in, ms_wr, ms_rd, d_stall, d_done},
                  {16'h0808, 16'h1234, 4'b1010});
            if (c == 3) begin d_addr = 16'hFFFF; d_data_in = 16'h0000; end
            step();
        end
        ms_done = 1; ms_cachehit = 0; settle();
        check("t3 done", {d_done, d_stall, d_hit, ms_addr}, {3'b100, 16'h0808});
        $display("txn t3 D write 0808 <- 1234");
        step();
        d_wr = 0; ms_done = 0; settle();
        check("t3 idle", {ms_wr, ms_rd, d_done}, 3'b000);
        step();
        check("t3 no regrant", {ms_wr, ms_rd}, 2'b00);

        // 6: no ms_done during a grant
        i_rd = 1; i_addr = 16'h0040;
        step();
`ifdef MEM_ARB_WDOG_EN
        k = 0;
        while (arb_err !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        check("t6 wdog cycles", k, 64);
        check("t6 wdog drop", {ms_rd, arb_err}, 2'b01);
        $display("txn t6 watchdog fired after %0d cycles", k);
`else
        repeat (70) step();
        check("t6 waits", {ms_rd, arb_err, i_stall}, 3'b101);
        ms_done = 1; settle();
        check("t6 late done", i_done, 1'b1);
        $display("txn t6 grant held 70 cycles");
        step();
        ms_done = 0;
`endif
        i_rd = 0;
        rst_n = 0; settle();
        step();
        rst_n = 1;

        // 5: ms_err during GNT_I, then reset mid-grant
        i_rd = 1; i_addr = 16'h0040;
        step();
        check("t5 grant", ms_rd, 1'b1);
        ms_err = 1; ms_done = 1; ms_cachehit = 1; settle();
        check("t5 err no done", {i_done, i_hit, i_data_out}, 18'h0);
        step();
        ms_err = 0; ms_done = 0; ms_cachehit = 0; settle();
        check("t5 err state", {arb_err, ms_rd, i_stall}, 3'b101);
        step();
        check("t5 no grant in err", ms_rd, 1'b0);
        $display("txn t5 ms_err during I grant");
        rst_n = 0; settle();
        rst_n = 1; i_rd = 0; d_rd = 1; d_addr = 16'h0300;
        step();
        check("t5 d grant", {ms_rd, ms_addr}, {1'b1, 16'h0300});
        rst_n = 0; settle();
        check("t5 async reset", {ms_rd, ms_wr, ms_addr, ms_data_in, arb_err}, 35'h0);
        d_rd = 0;
        step();
        rst_n = 1;

        // 4: illegal D op
        d_rd = 1; d_wr = 1; d_addr = 16'h0500;
        step();
        check("t4 illegal", {ms_rd, ms_wr, arb_err}, 3'b001);
        d_rd = 0; d_wr = 0; i_rd = 1;
        step(); step();
        check("t4 stuck", {ms_rd, i_stall, i_done}, 3'b010);
        d_wr = 1; settle();
        check("t4 d stall", {d_stall, d_done, ms_wr}, 3'b100);
        $display("txn t4 illegal d_rd&d_wr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
